// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the integer register file, its writeback sources
//   and the write-port arbiter.
//   Contents:
//     XLEN, REG_ADDR_WIDTH, REG_ZERO : architectural register file geometry
//     wb_req_t                       : one writeback request {port, data}
//     MAX_REQ, popcount_req()        : helpers for the write-port arbiter
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // Largest supported number of writeback requesters.
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] port;
        logic [XLEN-1:0]           data;
    } wb_req_t;

    // Number of set bits in a request vector, zero-extended to MAX_REQ bits.
    function automatic logic [3:0] popcount_req(input logic [MAX_REQ-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the writeback request handshake and the register file write port.
//   Signals:
//     stall        : suppresses grants for the cycle
//     req_valid    : per-requester pending write
//     req_port     : per-requester destination index (slice i = requester i)
//     req_data     : per-requester write value (slice i = requester i)
//     req_ready    : one-hot grant back to the requesters
//     write_enable : register file write strobe
//     write_port   : register file write index
//     write_data   : register file write value
//     grant_id     : requester that produced the current write
//   Modports:
//     master : writeback side / register file side (drives requests)
//     slave  : the arbiter (drives ready and the write port)
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);

    localparam int GID_WIDTH = $clog2(NUM_REQ);

    logic                          stall;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_port;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          write_enable;
    logic [ADDR_WIDTH-1:0]         write_port;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [GID_WIDTH-1:0]          grant_id;

    modport master (
        output stall, req_valid, req_port, req_data,
        input  req_ready, write_enable, write_port, write_data, grant_id
    );

    modport slave (
        input  stall, req_valid, req_port, req_data,
        output req_ready, write_enable, write_port, write_data, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Generic NUM_REQ-way round-robin arbiter. The search starts at rr_ptr and
//   wraps modulo NUM_REQ; after a grant to g the pointer moves to g+1 so the
//   winner becomes lowest priority next time.
//   Ports:
//     clock, reset_n : clock, asynchronous active-low reset
//     req            : request vector
//     enable         : when low, no grant is issued and the pointer holds
//     grant          : one-hot grant (all zero while reset_n is low)
//     grant_idx      : index of the granted requester
//     grant_valid    : a grant is issued this cycle
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 enable,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
    localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

    logic [IDX_WIDTH-1:0] rr_ptr;

    always_comb begin
        logic [IDX_WIDTH:0]   sum;
        logic [IDX_WIDTH-1:0] idx;
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        // reset_n gates the grant so requesters never see ready during reset.
        if (enable && reset_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr} + (IDX_WIDTH + 1)'(k);
                if (sum >= NUM_REQ_W) begin
                    sum = sum - NUM_REQ_W;
                end
                idx = sum[IDX_WIDTH-1:0];
                if (!grant_valid && req[idx]) begin
                    grant[idx]  = 1'b1;
                    grant_idx   = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the register file's single write port between NUM_REQ writeback
//   sources. A round-robin arbiter picks one valid requester per cycle; the
//   winner's index and value are captured in a registered output stage, so
//   the register file sees the write one cycle after the handshake. Writes to
//   x0 are accepted but never strobed. A saturating counter tracks cycles in
//   which two or more sources competed for the port.
//   Ports:
//     clock, reset_n  : clock, asynchronous active-low reset
//     bus (slave)     : request handshake and register file write port
//     collision_count : saturating count of cycles with >= 2 valid requests
// ----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus,
    output logic [CNT_WIDTH-1:0]    collision_count
);

    localparam int GID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    grant;
    logic [GID_WIDTH-1:0]  grant_idx;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] sel_port;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  collision;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (GID_WIDTH)
    ) u_rr_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (bus.req_valid),
        .enable      (!bus.stall),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign bus.req_ready = grant;

    // Winner's fields; only consumed when grant_valid is high.
    assign sel_port = bus.req_port[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = bus.req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

    // Contention is measured on raw valids, independent of stall.
    assign collision = popcount_req(MAX_REQ'(bus.req_valid)) >= 4'd2;

    // Output stage: port/data/id hold between transfers; only the strobe is
    // cleared, and it stays low for x0 so register 0 is never written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.write_enable <= 1'b0;
            bus.write_port   <= '0;
            bus.write_data   <= '0;
            bus.grant_id     <= '0;
        end else if (grant_valid) begin
            bus.write_enable <= (sel_port != ADDR_WIDTH'(REG_ZERO));
            bus.write_port   <= sel_port;
            bus.write_data   <= sel_data;
            bus.grant_id     <= grant_idx;
        end else begin
            bus.write_enable <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            collision_count <= '0;
        end else if (collision && !(&collision_count)) begin
            collision_count <= collision_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources, for example the ALU, the load unit and the mul/div unit.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Drives the register file write_port/write_data/write_enable from a registered output stage, so there is one cycle of latency.
- Sits between the execute/memory writeback sources and the register file. It also counts contention cycles for performance tuning.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, width of a register value.
- ADDR_WIDTH, 5, width of a register index.
- CNT_WIDTH, 16, width of the saturating collision counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- stall  in  1  when high, no grant is issued this cycle.
- req_valid  in  NUM_REQ  request i holds a pending write.
- req_port  in  NUM_REQ*ADDR_WIDTH  destination register index; slice i belongs to request i.
- req_data  in  NUM_REQ*DATA_WIDTH  write value; slice i belongs to request i.
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when valid and ready are both high.
- write_enable  out  1  register file write strobe.
- write_port  out  ADDR_WIDTH  register file write index.
- write_data  out  DATA_WIDTH  register file write value.
- grant_id  out  $clog2(NUM_REQ)  index of the requester driving the current output stage.
- collision_count  out  CNT_WIDTH  number of cycles in which two or more req_valid bits were high; saturates.

Behaviour:
- Reset (reset_n low, asynchronous):
  - write_enable, write_port, write_data, grant_id and collision_count go to 0.
  - The round-robin pointer rr_ptr goes to 0.
  - req_ready is forced to 0 while reset_n is low.
- Arbitration (combinational, every cycle with stall=0):
  - Scan requesters rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The first one with req_valid=1 gets req_ready=1; all other ready bits are 0.
  - req_ready is 0 when no request is valid.
  - req_ready never depends on a requester's own data.
- Stall: when stall=1, req_ready is all zeros, rr_ptr is held, and the next-cycle write_enable is 0.
- Pointer update on a transfer from requester g: rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr is unchanged.
- Output stage, on the clock edge after a transfer from g:
  - write_port <= req_port[g]
  - write_data <= req_data[g]
  - grant_id <= g
  - write_enable <= (req_port[g] != 0)
- Writes to x0:
  - They are accepted (ready asserted, pointer advances) and write_port/data are still captured.
  - write_enable stays 0, so register 0 is never written.
- No transfer in a cycle: write_enable <= 0. write_port, write_data and grant_id hold their last values.
- Throughput is one write per cycle. A single continuously valid requester is granted every cycle.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,0,... Any continuously valid requester waits at most NUM_REQ-1 cycles.
- Requesters must hold valid, port and data stable until they are accepted. The arbiter keeps no other buffering.
- Collision counter:
  - Increments each cycle in which popcount(req_valid) >= 2, regardless of stall.
  - Holds at all-ones once reached.
- Reset asserted mid-operation: the in-flight output-stage write is dropped (write_enable becomes 0 immediately) and the pointer returns to 0.
- No combinational path exists from stall or req_* to the write_* outputs.

Decomposition:
- Package regfile_pkg:
  - constants XLEN=32, REG_ADDR_WIDTH=5, REG_ZERO=5'd0
  - typedef wb_req_t = struct {port, data}
  - Shared with the register file and the writeback sources.
- Sub-module rr_arbiter:
  - Generic NUM_REQ round-robin arbiter with the rotating pointer register.
  - Inputs: req vector, enable. Outputs: one-hot grant, grant index.
  - Resets asynchronously on reset_n.
- regfile_write_arbiter instantiates rr_arbiter and adds the output stage, the x0 suppression and the counter.

Test Plan:
- Single request, requester 1 valid with port=5 and data=0xDEADBEEF, rr_ptr=0 → req_ready=3'b010 in the same cycle. Next cycle: write_enable=1, write_port=5, write_data=0xDEADBEEF, grant_id=1. The following cycle write_enable=0.
- All three valid for 6 cycles with distinct ports 1/2/3 → grant order 0,1,2,0,1,2. write_enable is high for 6 consecutive cycles. collision_count=6.
- Requester 0 valid with port=0 and data=0x1234 → req_ready[0]=1 and the pointer advances to 1. write_enable stays 0 the next cycle.
- stall=1 for 3 cycles with requesters 0 and 2 valid → req_ready=0 and write_enable=0 throughout, collision_count increments by 3. After stall drops, requester 0 is granted first.
- Pull reset_n low asynchronously mid-cycle while write_enable=1 → all outputs go to 0 immediately. After release, with requester 2 valid, the grant goes to 2 and the pointer becomes 0.
- Hold two requesters valid for 2^CNT_WIDTH+5 cycles (CNT_WIDTH=4 in the bench) → collision_count saturates at 15 and does not wrap.
